// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the lfsr sequencer/arbiter.
//   state_t       : controller FSM states
//   cmd_op_t      : command opcodes carried on cmd_op
//   ZERO_SEED_SUB : value loaded instead of an all-zero seed
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    WARM  = 2'b10,
    BURST = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SEED  = 2'b01,
    OP_BURST = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_t;

  // All-zero is the lfsr lock-up state, so a zero seed is replaced by this.
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grants allowed this cycle
//   req[1:0]   : level requests
//   gnt[1:0]   : one-hot grant, combinational (zero latency)
// A lone request always wins; on contention the pointer side wins. After
// every grant the pointer moves to the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// Sequencer and arbiter for the 8-bit lfsr.
// Accepts SEED/BURST commands, loads the seed, discards WARMUP steps, then
// shares the generator between two requesters round-robin (one grant = one
// byte + one lfsr step).
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake; cmd_op / cmd_arg carry the command
//   abort                : return to IDLE, highest priority
//   lfsr_we/lfsr_seed    : load the lfsr this cycle
//   lfsr_step            : advance the lfsr this cycle
//   lfsr_bits            : current lfsr state
//   req / gnt            : requester levels / one-hot grant
//   rnd_valid/rnd_data   : byte handed to the granted requester
//   busy, err, remaining : status (err is a one-cycle pulse)
module lfsr_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WARMUP = 8,
  parameter int NREQ   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             lfsr_we,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_step,
  input  logic [WIDTH-1:0] lfsr_bits,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic             busy,
  output logic             err,
  output logic [8:0]       remaining
);

  localparam int WC = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_t           state;
  logic             seeded;
  logic [WIDTH-1:0] seed_q;
  logic [WC-1:0]    warm_cnt;
  logic [8:0]       rem_q;
  logic             err_q;
  logic             accept;
  logic             arb_en;

  // abort is folded into every strobe so nothing takes effect in its cycle.
  assign cmd_ready = (state == IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign arb_en    = (state == BURST) && !abort;
  assign lfsr_we   = (state == LOAD) && !abort;
  assign lfsr_seed = lfsr_we ? seed_q : '0;
  assign rnd_valid = |gnt;
  assign rnd_data  = rnd_valid ? lfsr_bits : '0;
  assign lfsr_step = ((state == WARM) && !abort) || rnd_valid;
  assign busy      = (state != IDLE);
  assign err       = err_q;
  assign remaining = rem_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      seeded   <= 1'b0;
      seed_q   <= '0;
      warm_cnt <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && (cmd_op == OP_BURST) && !seeded;
      if (abort) begin
        state <= IDLE;
        rem_q <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              if (cmd_op == OP_SEED) begin
                // Zero substitution happens at latch time so LOAD just drives seed_q.
                seed_q <= (cmd_arg == '0) ? WIDTH'(ZERO_SEED_SUB) : cmd_arg;
                state  <= LOAD;
              end else if ((cmd_op == OP_BURST) && seeded) begin
                rem_q <= (cmd_arg == '0) ? 9'd256 : 9'(cmd_arg);
                state <= BURST;
              end
            end
          end
          LOAD: begin
            seeded   <= 1'b1;
            warm_cnt <= WC'(WARMUP - 1);
            state    <= WARM;
          end
          WARM: begin
            if (warm_cnt == '0) begin
              state <= IDLE;
            end else begin
              warm_cnt <= warm_cnt - 1'b1;
            end
          end
          BURST: begin
            if (rnd_valid) begin
              rem_q <= rem_q - 1'b1;
              if (rem_q == 9'd1) begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl: per-cycle vector table plus hand-written
// sequences for the 256-byte burst, abort mid-burst and async reset mid-warm.
module tb_lfsr_ctrl;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] SD  = 2'b01;
  localparam logic [1:0] BU  = 2'b10;
  localparam logic [1:0] RS  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic       lfsr_we;
  logic [7:0] lfsr_seed;
  logic       lfsr_step;
  logic [7:0] lfsr_bits;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic       busy;
  logic       err;
  logic [8:0] remaining;

  always #5 clk = ~clk;

  lfsr_ctrl #(.WIDTH(8), .WARMUP(8), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .lfsr_we   (lfsr_we),
    .lfsr_seed (lfsr_seed),
    .lfsr_step (lfsr_step),
    .lfsr_bits (lfsr_bits),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .busy      (busy),
    .err       (err),
    .remaining (remaining)
  );

  typedef struct packed {
    logic       rdy;
    logic       we;
    logic [7:0] seed;
    logic       step;
    logic [1:0] gnt;
    logic       vld;
    logic [7:0] dat;
    logic       busy;
    logic       err;
    logic [8:0] rem;
  } outs_t;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] arg;
    logic       ab;
    logic [1:0] req;
    logic [7:0] bits;
    outs_t      exp;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(
    input logic v, input logic [1:0] op, input logic [7:0] arg, input logic ab,
    input logic [1:0] rq, input logic [7:0] bits,
    input logic rdy, input logic we, input logic [7:0] seed, input logic step,
    input logic [1:0] g, input logic bsy, input logic er, input logic [8:0] rem);
    vec_t r;
    r.v = v; r.op = op; r.arg = arg; r.ab = ab; r.req = rq; r.bits = bits;
    r.exp.rdy  = rdy;
    r.exp.we   = we;
    r.exp.seed = seed;
    r.exp.step = step;
    r.exp.gnt  = g;
    r.exp.vld  = (g != 2'b00);
    r.exp.dat  = (g != 2'b00) ? bits : 8'h00;
    r.exp.busy = bsy;
    r.exp.err  = er;
    r.exp.rem  = rem;
    return r;
  endfunction

  function automatic outs_t act();
    return outs_t'({cmd_ready, lfsr_we, lfsr_seed, lfsr_step, gnt, rnd_valid,
                    rnd_data, busy, err, remaining});
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("rdy=%0b we=%0b seed=%h step=%0b gnt=%b vld=%0b dat=%h busy=%0b err=%0b rem=%0d",
                     o.rdy, o.we, o.seed, o.step, o.gnt, o.vld, o.dat, o.busy, o.err, o.rem);
  endfunction

  task automatic check(input string name, input outs_t a, input outs_t e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(e));
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic drive(input vec_t r);
    cmd_valid = r.v;
    cmd_op    = r.op;
    cmd_arg   = r.arg;
    abort     = r.ab;
    req       = r.req;
    lfsr_bits = r.bits;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic run_row(input string name, input vec_t r);
    @(posedge clk);
    #1;
    drive(r);
    @(negedge clk);
    check(name, act(), r.exp);
  endtask

  outs_t rst_vals;
  int    grants, step_bad, rem_bad, done;

  initial begin
    rst_vals = '0;
    rst_vals.rdy = 1'b1;

    rst_n = 1'b0;
    drive(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    @(negedge clk);
    check("reset state", act(), rst_vals);
    rst_n = 1'b1;

    // 1: BURST before any SEED -> error pulse, no grants, stays idle
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(1, BU,  8'h04, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h77, 1, 0, 8'h00, 0, 2'b00, 0, 1, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // 2: SEED A5 -> LOAD, 8 WARM steps (commands offered there are refused), IDLE
    tbl.push_back(mk(1, SD,  8'hA5, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 1, 8'hA5, 0, 2'b00, 1, 0, 9'd0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, SD, 8'h33, 0, 2'b11, 8'h00, 0, 0, 8'h00, 1, 2'b00, 1, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // reserved op accepted with no effect
    tbl.push_back(mk(1, RS,  8'hFF, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // abort in IDLE blocks a SEED
    tbl.push_back(mk(1, SD,  8'h44, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // 3: SEED 0 -> loads 01
    tbl.push_back(mk(1, SD,  8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 1, 8'h01, 0, 2'b00, 1, 0, 9'd0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 0, 8'h00, 1, 2'b00, 1, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // 4: BURST 4, both requesting -> alternate 01,10,01,10
    tbl.push_back(mk(1, BU,  8'h04, 0, 2'b11, 8'h10, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h21, 0, 0, 8'h00, 1, 2'b01, 1, 0, 9'd4));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h32, 0, 0, 8'h00, 1, 2'b10, 1, 0, 9'd3));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h43, 0, 0, 8'h00, 1, 2'b01, 1, 0, 9'd2));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h54, 0, 0, 8'h00, 1, 2'b10, 1, 0, 9'd1));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h65, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // BURST 2 with an idle no-request cycle; pointer is back at 0
    tbl.push_back(mk(1, BU,  8'h02, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h8B, 0, 0, 8'h00, 0, 2'b00, 1, 0, 9'd2));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b10, 8'h9C, 0, 0, 8'h00, 1, 2'b10, 1, 0, 9'd2));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'hC9, 0, 0, 8'h00, 1, 2'b01, 1, 0, 9'd1));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b11, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // abort in LOAD: no write
    tbl.push_back(mk(1, SD,  8'h3C, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 2'b00, 1, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // abort in WARM: step suppressed in the abort cycle
    tbl.push_back(mk(1, SD,  8'h11, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 1, 8'h11, 0, 2'b00, 1, 0, 9'd0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 0, 8'h00, 1, 2'b00, 1, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 2'b00, 1, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    // still seeded: BURST 1 runs, no err
    tbl.push_back(mk(1, BU,  8'h01, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b01, 8'hE7, 0, 0, 8'h00, 1, 2'b01, 1, 0, 9'd1));
    tbl.push_back(mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));

    foreach (tbl[i]) run_row($sformatf("row %0d", i), tbl[i]);

    // 5: BURST 0 = 256 bytes, requests cycling 01 / 00 / 10
    run_row("t5 accept", mk(1, BU, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    grants = 0; step_bad = 0; rem_bad = 0; done = 0;
    for (int i = 0; i < 1000 && done == 0; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      req       = (i % 3 == 0) ? 2'b01 : ((i % 3 == 1) ? 2'b00 : 2'b10);
      lfsr_bits = 8'(i) ^ 8'h5A;
      @(negedge clk);
      if (!busy) begin
        done = 1;
      end else if (req != 2'b00) begin
        if (remaining != 9'(256 - grants)) rem_bad++;
        if (gnt !== req || !lfsr_step || !rnd_valid || rnd_data !== lfsr_bits) step_bad++;
        grants++;
      end else if (gnt !== 2'b00 || lfsr_step || rnd_valid || rnd_data !== 8'h00) begin
        step_bad++;
      end
    end
    check_int("t5 burst finished in budget", done, 1);
    check_int("t5 grant count", grants, 256);
    check_int("t5 grant/step mismatches", step_bad, 0);
    check_int("t5 remaining mismatches", rem_bad, 0);
    check("t5 idle after burst", act(), rst_vals);

    // abort after two grants of a new burst
    run_row("t5b accept", mk(1, BU, 8'h00, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    run_row("t5b g1",     mk(0, NOP, 8'h00, 0, 2'b11, 8'h1F, 0, 0, 8'h00, 1, 2'b01, 1, 0, 9'd256));
    run_row("t5b g2",     mk(0, NOP, 8'h00, 0, 2'b11, 8'h2E, 0, 0, 8'h00, 1, 2'b10, 1, 0, 9'd255));
    run_row("t5b abort",  mk(0, NOP, 8'h00, 1, 2'b11, 8'h3D, 0, 0, 8'h00, 0, 2'b00, 1, 0, 9'd254));
    run_row("t5b idle",   mk(0, NOP, 8'h00, 0, 2'b11, 8'h4C, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));

    // 6: async reset in the middle of warm-up clears seeded
    run_row("t6 seed",  mk(1, SD, 8'h5E, 0, 2'b00, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    run_row("t6 load",  mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 1, 8'h5E, 0, 2'b00, 1, 0, 9'd0));
    run_row("t6 warm1", mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 0, 8'h00, 1, 2'b00, 1, 0, 9'd0));
    run_row("t6 warm2", mk(0, NOP, 8'h00, 0, 2'b00, 8'h00, 0, 0, 8'h00, 1, 2'b00, 1, 0, 9'd0));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async reset outputs", act(), rst_vals);
    @(negedge clk);
    rst_n = 1'b1;
    run_row("t6 burst", mk(1, BU, 8'h04, 0, 2'b11, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));
    run_row("t6 err",   mk(0, NOP, 8'h00, 0, 2'b11, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 1, 9'd0));
    run_row("t6 after", mk(0, NOP, 8'h00, 0, 2'b11, 8'h00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 9'd0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
